// File: rtl/npc_fetch_ctrl.sv
// Fetch-stage PC owner: picks the next PC from exception/eret/jump/branch/sequential
// sources and sequences imem fetches, parking redirects that arrive mid-fetch.
module npc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        j_taken_i,
   input  logic [31:0] j_target_i,
   input  logic        exc_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic        imem_ready_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        if_valid_o,
   output logic        adel_o
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nx_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nx_s;
   logic        pend_valid_r;
   logic        pend_valid_nx_s;
   logic [31:0] pend_addr_r;
   logic [31:0] pend_addr_nx_s;
   logic        req_r;
   logic        adel_r;
   logic        if_valid_s;
   logic        redir_hi_s;
   logic        redir_s;
   logic [31:0] redir_tgt_s;

   // Redirect request and target; D-stage jump/branch only count when the pipe advances
   always_comb begin
      redir_hi_s = exc_i | eret_i;
      redir_s    = redir_hi_s | (~stall_i & (j_taken_i | br_taken_i));
      if (exc_i) begin
         redir_tgt_s = EXC_PC;
      end else if (eret_i) begin
         redir_tgt_s = epc_i;
      end else if (j_taken_i) begin
         redir_tgt_s = j_target_i;
      end else begin
         redir_tgt_s = br_target_i;
      end
   end

   // Next-state, next-PC and pending-redirect selection
   always_comb begin
      state_nx_s      = state_r;
      pc_nx_s         = pc_r;
      pend_valid_nx_s = pend_valid_r;
      pend_addr_nx_s  = pend_addr_r;
      if_valid_s      = 1'b0;
      case (state_r)
         ST_BOOT: begin
            state_nx_s = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ready_i) begin
               // A redirect or parked target makes the returning instruction stale
               if (redir_s || pend_valid_r) begin
                  pc_nx_s         = redir_s ? redir_tgt_s : pend_addr_r;
                  pend_valid_nx_s = 1'b0;
               end else if (!stall_i) begin
                  if_valid_s = 1'b1;
                  pc_nx_s    = pc_r + 32'd4;
               end else begin
                  state_nx_s = ST_HOLD;
               end
            end else begin
               if (redir_s) begin
                  pend_valid_nx_s = 1'b1;
                  pend_addr_nx_s  = redir_tgt_s;
               end else begin
                  pend_valid_nx_s = pend_valid_r;
               end
            end
         end
         ST_HOLD: begin
            if (redir_hi_s) begin
               pc_nx_s    = redir_tgt_s;
               state_nx_s = ST_FETCH;
            end else if (!stall_i) begin
               state_nx_s = ST_FETCH;
            end else begin
               state_nx_s = ST_HOLD;
            end
         end
         default: begin
            state_nx_s = ST_BOOT;
         end
      endcase
   end

   // State, PC, pending redirect and registered request/misalign outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_BOOT;
         pc_r         <= RESET_PC;
         pend_valid_r <= 1'b0;
         pend_addr_r  <= 32'd0;
         req_r        <= 1'b0;
         adel_r       <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         pc_r         <= pc_nx_s;
         pend_valid_r <= pend_valid_nx_s;
         pend_addr_r  <= pend_addr_nx_s;
         req_r        <= (state_nx_s == ST_FETCH);
         adel_r       <= (state_nx_s == ST_FETCH) && (pc_nx_s[1:0] != 2'b00);
      end
   end

   assign imem_req_o  = req_r;
   assign imem_addr_o = pc_r;
   assign pc_o        = pc_r;
   assign pc4_o       = pc_r + 32'd4;
   assign if_valid_o  = if_valid_s;
   assign adel_o      = adel_r;

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Bench for npc_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural fetch model.
module tb_npc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        br_taken_i = 1'b0;
   logic [31:0] br_target_i = 32'd0;
   logic        j_taken_i = 1'b0;
   logic [31:0] j_target_i = 32'd0;
   logic        exc_i = 1'b0;
   logic        eret_i = 1'b0;
   logic [31:0] epc_i = 32'd0;
   logic        imem_ready_i = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] pc_o;
   logic [31:0] pc4_o;
   logic        if_valid_o;
   logic        adel_o;

   int n_total = 0;
   int n_bad   = 0;

   npc_fetch_ctrl #(.RESET_PC(RST_PC), .EXC_PC(EXC_PC)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i),
      .br_taken_i(br_taken_i), .br_target_i(br_target_i),
      .j_taken_i(j_taken_i), .j_target_i(j_target_i),
      .exc_i(exc_i), .eret_i(eret_i), .epc_i(epc_i),
      .imem_ready_i(imem_ready_i), .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o), .pc_o(pc_o), .pc4_o(pc4_o),
      .if_valid_o(if_valid_o), .adel_o(adel_o)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: fetch engine is booting, holding, or fetching; parked redirect is a queue
   logic        m_boot = 1'b1;
   logic        m_hold = 1'b0;
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_pend[$];

   initial begin
      logic        e_req, e_valid, redir;
      logic [31:0] tgt;
      forever begin
         @(negedge clk);
         if (reset) begin
            cmp1("rst_req", imem_req_o, 1'b0);
            cmp1("rst_valid", if_valid_o, 1'b0);
            cmp1("rst_adel", adel_o, 1'b0);
            cmp("rst_pc", pc_o, RST_PC);
            m_boot = 1'b1;
            m_hold = 1'b0;
            m_pc   = RST_PC;
            m_pend.delete();
         end else begin
            e_req = !m_boot && !m_hold;
            redir = exc_i || eret_i || (!stall_i && (j_taken_i || br_taken_i));
            tgt   = exc_i ? EXC_PC : eret_i ? epc_i : j_taken_i ? j_target_i : br_target_i;
            e_valid = e_req && imem_ready_i && !redir && (m_pend.size() == 0) && !stall_i;
            cmp1("req", imem_req_o, e_req);
            cmp("pc", pc_o, m_pc);
            cmp("addr", imem_addr_o, m_pc);
            cmp("pc4", pc4_o, m_pc + 32'd4);
            cmp1("if_valid", if_valid_o, e_valid);
            cmp1("adel", adel_o, e_req && (m_pc % 4 != 0));
            if (m_boot) begin
               m_boot = 1'b0;
            end else if (m_hold) begin
               if (exc_i || eret_i) begin
                  m_pc   = tgt;
                  m_hold = 1'b0;
               end else if (!stall_i) begin
                  m_hold = 1'b0;
               end
            end else if (imem_ready_i) begin
               if (redir) begin
                  m_pc = tgt;
                  m_pend.delete();
               end else if (m_pend.size() != 0) begin
                  m_pc = m_pend.pop_front();
               end else if (!stall_i) begin
                  m_pc = m_pc + 32'd4;
               end else begin
                  m_hold = 1'b1;
               end
            end else if (redir) begin
               m_pend.delete();
               m_pend.push_back(tgt);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_i = 1'b0; br_taken_i = 1'b0; j_taken_i = 1'b0;
      exc_i = 1'b0; eret_i = 1'b0;
   endtask

   function automatic logic [31:0] rand_tgt();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 15) != 0) r[1:0] = 2'b00;
      return r;
   endfunction

   initial begin
      tick(); tick();
      reset = 1'b0;                                   // released just after an edge
      #1; cmp1("boot_req", imem_req_o, 1'b0); cmp("boot_pc", pc_o, 32'h3000);
      tick(); #1; cmp("seq0", imem_addr_o, 32'h3000); cmp1("seq0_v", if_valid_o, 1'b1);
      tick(); #1; cmp("seq1", imem_addr_o, 32'h3004); cmp1("seq1_v", if_valid_o, 1'b1);
      tick(); j_taken_i = 1'b1; j_target_i = 32'h3100;
      #1; cmp("seq2", imem_addr_o, 32'h3008); cmp1("jmp_v", if_valid_o, 1'b0);
      tick(); idle(); br_taken_i = 1'b1; br_target_i = 32'h3010;
      #1; cmp("jmp_addr", imem_addr_o, 32'h3100);
      tick(); idle(); imem_ready_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h3040;
      #1; cmp("pend_a0", imem_addr_o, 32'h3010);
      tick(); idle(); #1; cmp("pend_a1", imem_addr_o, 32'h3010);
      tick(); #1; cmp("pend_a2", imem_addr_o, 32'h3010);
      tick(); imem_ready_i = 1'b1;
      #1; cmp("pend_a3", imem_addr_o, 32'h3010); cmp1("pend_v", if_valid_o, 1'b0);
      tick(); br_taken_i = 1'b1; br_target_i = 32'h3020;
      #1; cmp("pend_new", imem_addr_o, 32'h3040);
      tick(); idle(); stall_i = 1'b1;
      #1; cmp("hold_a", imem_addr_o, 32'h3020); cmp1("hold_v", if_valid_o, 1'b0);
      tick(); #1; cmp1("hold_req", imem_req_o, 1'b0);
      tick(); stall_i = 1'b0; #1; cmp1("hold_req2", imem_req_o, 1'b0);
      tick(); #1; cmp("refetch", imem_addr_o, 32'h3020); cmp1("refetch_v", if_valid_o, 1'b1);
      tick(); exc_i = 1'b1; eret_i = 1'b1; j_taken_i = 1'b1; epc_i = 32'h3058;
      #1; cmp("after_hold", imem_addr_o, 32'h3024);
      tick(); idle(); stall_i = 1'b1;
      #1; cmp("exc_addr", imem_addr_o, 32'h4180);
      tick(); eret_i = 1'b1; #1; cmp1("hold2_req", imem_req_o, 1'b0);
      tick(); idle();
      #1; cmp("eret_addr", imem_addr_o, 32'h3058); cmp1("eret_v", if_valid_o, 1'b1);
      tick(); br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
      #1; cmp("seq305c", imem_addr_o, 32'h305C);
      tick(); idle();
      #1; cmp("wrap_pc", pc_o, 32'hFFFF_FFFC); cmp("wrap_pc4", pc4_o, 32'h0000_0000);
      tick(); br_taken_i = 1'b1; br_target_i = 32'h3002;
      #1; cmp("wrapped", pc_o, 32'h0000_0000);
      tick(); idle(); br_taken_i = 1'b1; br_target_i = 32'h3010;
      #1; cmp("mis_addr", imem_addr_o, 32'h3002); cmp1("mis_adel", adel_o, 1'b1);
      tick(); idle(); imem_ready_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h3200;
      #1; cmp1("al_adel", adel_o, 1'b0); cmp("al_addr", imem_addr_o, 32'h3010);
      tick(); idle(); #1; reset = 1'b1;
      #1; cmp("arst_pc", pc_o, 32'h3000); cmp1("arst_req", imem_req_o, 1'b0);
      tick(); reset = 1'b0; imem_ready_i = 1'b1;
      #1; cmp1("arst_boot", imem_req_o, 1'b0);
      tick(); #1; cmp("arst_f0", imem_addr_o, 32'h3000);
      tick(); #1; cmp("arst_f1", imem_addr_o, 32'h3004);

      for (int i = 0; i < 3000; i++) begin
         tick();
         reset        = ($urandom_range(0, 299) == 0);
         imem_ready_i = ($urandom_range(0, 3) != 0);
         stall_i      = ($urandom_range(0, 4) == 0);
         br_taken_i   = ($urandom_range(0, 7) == 0);
         br_target_i  = rand_tgt();
         j_taken_i    = ($urandom_range(0, 11) == 0);
         j_target_i   = rand_tgt();
         exc_i        = ($urandom_range(0, 39) == 0);
         eret_i       = ($urandom_range(0, 39) == 0);
         epc_i        = rand_tgt();
      end
      tick(); reset = 1'b0; idle();
      tick(); tick();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
